// File: rtl/wb_stage_pkg.sv
// Shared constants, state encoding and helpers for the write-back stage and
// its system-register file.
package wb_stage_pkg;

  localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;

  localparam logic [1:0]  SR_EPC       = 2'd0;
  localparam logic [1:0]  SR_ECAUSE    = 2'd1;
  localparam logic [1:0]  SR_STATUS    = 2'd2;
  localparam logic [1:0]  SR_SCRATCH   = 2'd3;

  localparam logic [31:0] ECAUSE_SCALL = 32'd1;
  localparam logic [31:0] ECAUSE_UDF   = 32'd2;
  localparam logic [1:0]  STATUS_RESET = 2'b01;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } wb_state_e;

  // Trap entry saves the current privilege in STATUS[1] and enters kernel mode.
  function automatic logic [1:0] status_on_trap(input logic [1:0] status);
    return {status[0], 1'b1};
  endfunction

  // Exception return restores the saved privilege.
  function automatic logic [1:0] status_on_eret(input logic [1:0] status);
    return {status[1], status[1]};
  endfunction

endpackage

// File: rtl/wb_sysregs.sv
// System-register file: EPC, ECAUSE, STATUS, SCRATCH with a combinational
// read port and trap / exception-return / move-to-SR updates.
module wb_sysregs
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        act_udf,
  input  logic        act_scall,
  input  logic        act_eret,
  input  logic        act_mtsr,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_nextpc,
  input  logic [1:0]  sr_widx,
  input  logic [31:0] sr_wdata,
  input  logic [1:0]  sr_raddr,
  output logic [31:0] sr_rdata,
  output logic [31:0] epc,
  output logic        kmode
);

  logic [31:0] epc_r;
  logic [31:0] ecause_r;
  logic [1:0]  status_r;
  logic [31:0] scratch_r;

  // Register update; the act_* inputs are already mutually exclusive by priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_r     <= 32'd0;
      ecause_r  <= 32'd0;
      status_r  <= STATUS_RESET;
      scratch_r <= 32'd0;
    end else if (act_udf) begin
      epc_r    <= trap_pc;
      ecause_r <= ECAUSE_UDF;
      status_r <= status_on_trap(status_r);
    end else if (act_scall) begin
      epc_r    <= trap_nextpc;
      ecause_r <= ECAUSE_SCALL;
      status_r <= status_on_trap(status_r);
    end else if (act_eret) begin
      status_r <= status_on_eret(status_r);
    end else if (act_mtsr) begin
      case (sr_widx)
        SR_EPC:     epc_r     <= sr_wdata;
        SR_ECAUSE:  ecause_r  <= sr_wdata;
        SR_STATUS:  status_r  <= sr_wdata[1:0];
        SR_SCRATCH: scratch_r <= sr_wdata;
        default:    scratch_r <= scratch_r;
      endcase
    end else begin
      epc_r <= epc_r;
    end
  end

  // Read port shows registered contents only; no same-cycle forwarding.
  always_comb begin
    sr_rdata = 32'd0;
    case (sr_raddr)
      SR_EPC:     sr_rdata = epc_r;
      SR_ECAUSE:  sr_rdata = ecause_r;
      SR_STATUS:  sr_rdata = {30'd0, status_r};
      SR_SCRATCH: sr_rdata = scratch_r;
      default:    sr_rdata = 32'd0;
    endcase
  end

  assign epc   = epc_r;
  assign kmode = status_r[0];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits the MEM slot to RF/CR, handles traps and eret
// with a one-cycle FLUSH redirect, and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_nextpc,
  input  logic [31:0] m_res,
  input  logic [4:0]  m_rd,
  input  logic        m_w_rd,
  input  logic [1:0]  m_cmp_res,
  input  logic        m_w_cr,
  input  logic [31:0] m_op3,
  input  logic [31:0] m_alu_res,
  input  logic        m_mtsr,
  input  logic        m_scall,
  input  logic        m_eret,
  input  logic        m_udf,
  input  logic        m_bubble,
  input  logic        m_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        cr_we,
  output logic [1:0]  cr_wdata,
  input  logic [1:0]  sr_raddr,
  output logic [31:0] sr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] retired,
  output logic        kmode
);

  wb_state_e   state_r, state_n_s;
  logic        commit_s, trap_s;
  logic        act_udf_s, act_scall_s, act_eret_s, act_mtsr_s;
  logic [31:0] epc_s;
  logic [31:0] redirect_pc_n_s;
  logic        unused_alu_hi_s;

  assign unused_alu_hi_s = ^m_alu_res[31:2];

  assign commit_s    = (state_r == ST_RUN) & ~m_bubble & ~m_stall;
  assign trap_s      = m_udf | m_scall | m_eret;
  assign act_udf_s   = commit_s & m_udf;
  assign act_scall_s = commit_s & m_scall & ~m_udf;
  assign act_eret_s  = commit_s & m_eret & ~m_udf & ~m_scall;
  assign act_mtsr_s  = commit_s & m_mtsr & ~trap_s;

  assign rf_we    = commit_s & m_w_rd & (m_rd != 5'd0) & ~trap_s;
  assign rf_waddr = m_rd;
  assign rf_wdata = m_res;
  assign cr_we    = commit_s & m_w_cr & ~trap_s;
  assign cr_wdata = m_cmp_res;

  wb_sysregs u_sysregs (
    .clk         (clk),
    .rst         (rst),
    .act_udf     (act_udf_s),
    .act_scall   (act_scall_s),
    .act_eret    (act_eret_s),
    .act_mtsr    (act_mtsr_s),
    .trap_pc     (m_pc),
    .trap_nextpc (m_nextpc),
    .sr_widx     (m_alu_res[1:0]),
    .sr_wdata    (m_op3),
    .sr_raddr    (sr_raddr),
    .sr_rdata    (sr_rdata),
    .epc         (epc_s),
    .kmode       (kmode)
  );

  // Next state and redirect target; FLUSH always lasts exactly one cycle.
  always_comb begin
    state_n_s       = state_r;
    redirect_pc_n_s = redirect_pc;
    case (state_r)
      ST_RUN: begin
        if (commit_s & trap_s) begin
          state_n_s = ST_FLUSH;
        end else begin
          state_n_s = ST_RUN;
        end
      end
      ST_FLUSH: state_n_s = ST_RUN;
      default:  state_n_s = ST_RUN;
    endcase
    if (act_udf_s | act_scall_s) begin
      redirect_pc_n_s = TRAP_VEC;
    end else if (act_eret_s) begin
      redirect_pc_n_s = epc_s;
    end else begin
      redirect_pc_n_s = redirect_pc;
    end
  end

  // State, redirect and retired-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      retired     <= 32'd0;
    end else begin
      state_r     <= state_n_s;
      redirect    <= (state_n_s == ST_FLUSH);
      redirect_pc <= redirect_pc_n_s;
      retired     <= commit_s ? retired + 32'd1 : retired;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven commit vectors with a
// scoreboard queue, plus hand-written trap, eret, stall and wrap sequences.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_pc, m_nextpc, m_res, m_op3, m_alu_res;
  logic [4:0]  m_rd;
  logic        m_w_rd, m_w_cr, m_mtsr, m_scall, m_eret, m_udf, m_bubble, m_stall;
  logic [1:0]  m_cmp_res, sr_raddr, cr_wdata;
  logic        rf_we, cr_we, redirect, kmode;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, sr_rdata, redirect_pc, retired;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_retired;

  typedef struct {
    logic        bubble, stall, w_rd;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        w_cr;
    logic [1:0]  cmp;
    logic        e_rf_we, e_cr_we, e_commit;
  } vec_t;

  typedef struct {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        cr_we;
    logic [1:0]  cr_wdata;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  always #10 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .m_pc(m_pc), .m_nextpc(m_nextpc), .m_res(m_res),
    .m_rd(m_rd), .m_w_rd(m_w_rd), .m_cmp_res(m_cmp_res), .m_w_cr(m_w_cr),
    .m_op3(m_op3), .m_alu_res(m_alu_res), .m_mtsr(m_mtsr), .m_scall(m_scall),
    .m_eret(m_eret), .m_udf(m_udf), .m_bubble(m_bubble), .m_stall(m_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cr_we(cr_we),
    .cr_wdata(cr_wdata), .sr_raddr(sr_raddr), .sr_rdata(sr_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .retired(retired), .kmode(kmode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_sr(input string name, input logic [1:0] idx, input logic [31:0] exp);
    sr_raddr = idx;
    #1;
    chk(name, sr_rdata, exp);
  endtask

  task automatic clear_inputs();
    m_pc = 32'd0; m_nextpc = 32'd0; m_res = 32'd0; m_op3 = 32'd0; m_alu_res = 32'd0;
    m_rd = 5'd0; m_w_rd = 1'b0; m_cmp_res = 2'd0; m_w_cr = 1'b0;
    m_mtsr = 1'b0; m_scall = 1'b0; m_eret = 1'b0; m_udf = 1'b0;
    m_bubble = 1'b0; m_stall = 1'b0; sr_raddr = 2'd0;
  endtask

  // Advance past the next rising edge so registered outputs can be sampled.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Compare the write-port outputs against the oldest scoreboard entry.
  task automatic check_ports(input string name);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard empty actual=0 expected=1", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_rf_we"}, {31'd0, rf_we}, {31'd0, e.rf_we});
      chk({name, "_waddr"}, {27'd0, rf_waddr}, {27'd0, e.waddr});
      chk({name, "_wdata"}, rf_wdata, e.wdata);
      chk({name, "_cr_we"}, {31'd0, cr_we}, {31'd0, e.cr_we});
      chk({name, "_cr_wdata"}, {30'd0, cr_wdata}, {30'd0, e.cr_wdata});
    end
  endtask

  task automatic push_exp(input logic we, input logic cwe);
    sb.push_back('{rf_we: we, waddr: m_rd, wdata: m_res, cr_we: cwe, cr_wdata: m_cmp_res});
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h1234_5678, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_0077, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 5'd7,  32'h0000_0078, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 5'd9,  32'h0000_0009, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 5'd1,  32'h0000_0000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1};

    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_kmode", {31'd0, kmode}, 32'd1);
    chk_sr("rst_epc", SR_EPC, 32'd0);
    chk_sr("rst_ecause", SR_ECAUSE, 32'd0);
    chk_sr("rst_status", SR_STATUS, 32'd1);
    chk_sr("rst_scratch", SR_SCRATCH, 32'd0);
    exp_retired = 32'd0;

    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      m_bubble = vecs[i].bubble; m_stall = vecs[i].stall; m_w_rd = vecs[i].w_rd;
      m_rd = vecs[i].rd; m_res = vecs[i].res; m_w_cr = vecs[i].w_cr; m_cmp_res = vecs[i].cmp;
      push_exp(vecs[i].e_rf_we, vecs[i].e_cr_we);
      check_ports($sformatf("vec%0d", i));
      cycle();
      if (vecs[i].e_commit) exp_retired = exp_retired + 32'd1;
      chk($sformatf("vec%0d_retired", i), retired, exp_retired);
      chk($sformatf("vec%0d_redirect", i), {31'd0, redirect}, 32'd0);
    end

    // scall commits and traps; rd write is suppressed.
    clear_inputs();
    m_scall = 1'b1; m_pc = 32'h1000; m_nextpc = 32'h1004; m_w_rd = 1'b1; m_rd = 5'd3;
    m_res = 32'h3333_3333; m_w_cr = 1'b1;
    push_exp(1'b0, 1'b0);
    check_ports("scall");
    cycle();
    exp_retired = exp_retired + 32'd1;
    chk("scall_redirect", {31'd0, redirect}, 32'd1);
    chk("scall_redirect_pc", redirect_pc, 32'h100);
    chk("scall_retired", retired, exp_retired);
    chk_sr("scall_epc", SR_EPC, 32'h1004);
    chk_sr("scall_ecause", SR_ECAUSE, 32'd1);
    chk_sr("scall_status", SR_STATUS, 32'd3);

    // Slot presented during FLUSH is discarded.
    clear_inputs();
    m_w_rd = 1'b1; m_rd = 5'd4; m_res = 32'h4444_4444; m_w_cr = 1'b1;
    push_exp(1'b0, 1'b0);
    check_ports("flush_slot");
    cycle();
    chk("flush_retired", retired, exp_retired);
    chk("flush_exit_redirect", {31'd0, redirect}, 32'd0);
    chk("flush_exit_redirect_pc", redirect_pc, 32'h100);

    // mtsr STATUS <= 0 is not forwarded in the same cycle.
    clear_inputs();
    m_mtsr = 1'b1; m_alu_res = 32'hFFFF_FFF2; m_op3 = 32'd0;
    chk_sr("mtsr_no_fwd", SR_STATUS, 32'd3);
    cycle();
    exp_retired = exp_retired + 32'd1;
    chk_sr("mtsr_status", SR_STATUS, 32'd0);
    chk("mtsr_kmode", {31'd0, kmode}, 32'd0);
    chk("mtsr_redirect", {31'd0, redirect}, 32'd0);

    // eret returns to EPC and restores user mode.
    clear_inputs();
    m_eret = 1'b1;
    cycle();
    exp_retired = exp_retired + 32'd1;
    chk("eret_redirect", {31'd0, redirect}, 32'd1);
    chk("eret_redirect_pc", redirect_pc, 32'h1004);
    chk("eret_kmode", {31'd0, kmode}, 32'd0);
    clear_inputs();
    cycle();

    // udf wins over scall.
    clear_inputs();
    m_udf = 1'b1; m_scall = 1'b1; m_w_rd = 1'b1; m_rd = 5'd9; m_res = 32'h9999_9999;
    m_pc = 32'h2000; m_nextpc = 32'h2004;
    push_exp(1'b0, 1'b0);
    check_ports("udf");
    cycle();
    exp_retired = exp_retired + 32'd1;
    chk_sr("udf_ecause", SR_ECAUSE, 32'd2);
    chk_sr("udf_epc", SR_EPC, 32'h2000);
    chk_sr("udf_status", SR_STATUS, 32'd1);
    chk("udf_redirect_pc", redirect_pc, 32'h100);
    chk("udf_retired", retired, exp_retired);
    clear_inputs();
    cycle();

    // scall held by stall for three cycles, then released.
    clear_inputs();
    m_scall = 1'b1; m_pc = 32'h3000; m_nextpc = 32'h3004; m_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("stall%0d_redirect", i), {31'd0, redirect}, 32'd0);
      chk($sformatf("stall%0d_retired", i), retired, exp_retired);
      chk_sr($sformatf("stall%0d_epc", i), SR_EPC, 32'h2000);
    end
    m_stall = 1'b0;
    cycle();
    exp_retired = exp_retired + 32'd1;
    chk("release_redirect", {31'd0, redirect}, 32'd1);
    chk_sr("release_epc", SR_EPC, 32'h3004);
    chk_sr("release_status", SR_STATUS, 32'd3);
    clear_inputs();
    cycle();
    chk("release_once", {31'd0, redirect}, 32'd0);

    // Counter wrap: preset the counter, then one more commit.
    clear_inputs();
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    #1;
    chk("wrap_preset", retired, 32'hFFFF_FFFF);
    cycle();
    chk("wrap_retired", retired, 32'd0);

    // Reset asserted while in FLUSH, with a trap also presented.
    clear_inputs();
    m_scall = 1'b1; m_pc = 32'h5000; m_nextpc = 32'h5004;
    cycle();
    chk("pre_rst_redirect", {31'd0, redirect}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_inputs();
    chk("rst_flush_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_flush_redirect_pc", redirect_pc, 32'd0);
    chk("rst_flush_retired", retired, 32'd0);
    chk_sr("rst_flush_status", SR_STATUS, 32'd1);
    chk_sr("rst_flush_epc", SR_EPC, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
